ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte to the keyboard. Typical commands are 0xED (set LEDs), 0xF3 (typematic rate) and 0xFF (reset). It sits beside the existing PS/2 receiver on the same 50 MHz clock and drives the shared PS2_CLK/PS2_DATA lines as open-drain (drive-low enables only). It runs the full inhibit / request-to-send / device-clocked frame / ACK sequence and reports done or error. While this block is busy, the receiver must ignore line activity.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_filter.sv | 40 ++++
 rtl/ps2_transmitter.sv | 192 +++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry and
// the keyboard command/response bytes used by host-side logic.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_ACK,
      ST_RELEASE
   } ps2_tx_state_e;

   localparam int PS2_FRAME_BITS = 10;
   localparam int PS2_CNT_W      = 20;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_RESEND   = 8'hFE;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only
// follows the line after FILTER_LEN consecutive equal samples. Idles high.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic line_out
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         cnt      <= '0;
         line_out <= 1'b1;
      end else begin
         sync1 <= line_in;
         sync2 <= sync1;
         // Any sample matching the accepted level restarts the run count.
         if (sync2 == line_out) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            line_out <= sync2;
            cnt      <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send,
// device-clocked 10-bit frame, ACK check, then done or error.
module ps2_transmitter
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES    = 6000,
   parameter int START_HOLD_CYCLES = 100,
   parameter int TIMEOUT_CYCLES    = 1_000_000,
   parameter int FILTER_LEN        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy,
   input  logic       kclk_in,
   input  logic       kdata_in,
   output logic       kclk_oe,
   output logic       kdata_oe
);

   localparam logic [PS2_CNT_W-1:0] INHIBIT_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [PS2_CNT_W-1:0] HOLD_LAST    = PS2_CNT_W'(START_HOLD_CYCLES - 1);
   localparam logic [PS2_CNT_W-1:0] TIMEOUT_LAST = PS2_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]           LAST_BIT     = 4'(PS2_FRAME_BITS - 1);

   // Handshake: a byte is accepted in the cycle tx_valid and tx_ready are both
   // high; tx_ready is only high in IDLE, so requests elsewhere are ignored.

   ps2_tx_state_e                 state, state_n;
   logic [PS2_CNT_W-1:0]          cnt, cnt_n;
   logic [PS2_FRAME_BITS-1:0]     shift, shift_n;
   logic [3:0]                    bit_cnt, bit_cnt_n;
   logic                          kdata_n;
   logic                          done_n;
   logic                          err_n;
   logic                          kclk_f;
   logic                          kdata_f;
   logic                          kclk_f_q;
   logic                          kclk_fall;
   logic                          timeout;
   logic                          keep_cnt;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filter (
      .clk      (clk),
      .rst      (rst),
      .line_in  (kclk_in),
      .line_out (kclk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filter (
      .clk      (clk),
      .rst      (rst),
      .line_in  (kdata_in),
      .line_out (kdata_f)
   );

   assign kclk_fall = kclk_f_q & ~kclk_f;

   always_comb begin
      timeout = 1'b0;
      if (state == ST_SEND || state == ST_ACK || state == ST_RELEASE) begin
         timeout = (cnt == TIMEOUT_LAST);
      end
   end

   always_comb begin
      state_n   = state;
      shift_n   = shift;
      bit_cnt_n = bit_cnt;
      kdata_n   = kdata_oe;
      done_n    = 1'b0;
      err_n     = 1'b0;

      case (state)
         ST_IDLE: begin
            kdata_n = 1'b0;
            if (tx_valid && tx_ready) begin
               shift_n = {1'b1, odd_parity(tx_data), tx_data};
               state_n = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
               kdata_n = 1'b1;
               state_n = ST_RTS;
            end
         end

         ST_RTS: begin
            kdata_n = 1'b1;
            if (cnt == HOLD_LAST) begin
               bit_cnt_n = '0;
               state_n   = ST_SEND;
            end
         end

         ST_SEND: begin
            if (timeout) begin
               kdata_n = 1'b0;
               err_n   = 1'b1;
               state_n = ST_IDLE;
            end else if (kclk_fall) begin
               // Driving low encodes a 0; the final stop bit releases the line.
               kdata_n   = ~shift[0];
               shift_n   = {1'b0, shift[PS2_FRAME_BITS-1:1]};
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == LAST_BIT) begin
                  state_n = ST_ACK;
               end
            end
         end

         ST_ACK: begin
            kdata_n = 1'b0;
            if (timeout) begin
               err_n   = 1'b1;
               state_n = ST_IDLE;
            end else if (kclk_fall) begin
               if (!kdata_f) begin
                  state_n = ST_RELEASE;
               end else begin
                  err_n   = 1'b1;
                  state_n = ST_IDLE;
               end
            end
         end

         ST_RELEASE: begin
            kdata_n = 1'b0;
            if (timeout) begin
               err_n   = 1'b1;
               state_n = ST_IDLE;
            end else if (kclk_f && kdata_f) begin
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end
         end

         default: begin
            kdata_n = 1'b0;
            state_n = ST_IDLE;
         end
      endcase
   end

   // The counter restarts on each state change, except that the watchdog
   // keeps running from kclk release through ACK and the final release.
   always_comb begin
      keep_cnt = (state == ST_SEND && state_n == ST_ACK) ||
                 (state == ST_ACK  && state_n == ST_RELEASE);
      if (state_n != state && !keep_cnt) begin
         cnt_n = '0;
      end else begin
         cnt_n = cnt + PS2_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         shift    <= '0;
         bit_cnt  <= '0;
         kclk_f_q <= 1'b1;
         tx_ready <= 1'b0;
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
         busy     <= 1'b0;
         kclk_oe  <= 1'b0;
         kdata_oe <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         shift    <= shift_n;
         bit_cnt  <= bit_cnt_n;
         kclk_f_q <= kclk_f;
         // Ready is withheld during the done/error pulse cycle.
         tx_ready <= (state_n == ST_IDLE) && !done_n && !err_n;
         tx_done  <= done_n;
         tx_err   <= err_n;
         busy     <= (state_n != ST_IDLE);
         kclk_oe  <= (state_n == ST_INHIBIT) || (state_n == ST_RTS);
         kdata_oe <= kdata_n;
      end
   end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Table-driven bench for ps2_transmitter with a device-side bus model that
// clocks the frame, captures bits on rising edges and optionally ACKs.
module tb_ps2_transmitter;
   import ps2_pkg::*;

   localparam int INH  = 60;
   localparam int HOLD = 10;
   localparam int TMO  = 3000;
   localparam int FLT  = 8;
   localparam int HALF = 50;

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         exp_par;
      int         exp_done;
      int         exp_err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err, busy, kclk_oe, kdata_oe;
   logic       bfm_clk_low = 1'b0;
   logic       bfm_data_low = 1'b0;

   wire kclk_line  = ~(kclk_oe | bfm_clk_low);
   wire kdata_line = ~(kdata_oe | bfm_data_low);

   ps2_transmitter #(
      .INHIBIT_CYCLES    (INH),
      .START_HOLD_CYCLES (HOLD),
      .TIMEOUT_CYCLES    (TMO),
      .FILTER_LEN        (FLT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_done  (tx_done),
      .tx_err   (tx_err),
      .busy     (busy),
      .kclk_in  (kclk_line),
      .kdata_in (kdata_line),
      .kclk_oe  (kclk_oe),
      .kdata_oe (kdata_oe)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #(20 * 60000);
      $display("FAIL global_timeout: simulation ran past its cycle budget");
      $fatal(1, "global timeout");
   end

   // ---------------- scoreboard counters / monitor ----------------
   int checks = 0;
   int errors = 0;

   int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
   int acc_cyc = 0, err_cyc = 0;
   int kclk_rise_cyc = 0, kclk_fall_cyc = 0, kdata_rise_cyc = 0;
   bit both_flag = 1'b0, seq_bad = 1'b0;
   logic prev_kclk = 1'b0, prev_kdata = 1'b0, prev_pulse = 1'b0;

   always @(negedge clk) begin
      if (!prev_kclk && kclk_oe) kclk_rise_cyc = cyc;
      if (prev_kclk && !kclk_oe) kclk_fall_cyc = cyc;
      if (!prev_kdata && kdata_oe && kclk_oe) kdata_rise_cyc = cyc;
      if (tx_valid && tx_ready) begin
         acc_cyc = cyc;
         acc_cnt++;
      end
      if (tx_done) done_cnt++;
      if (tx_err) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (tx_done && tx_err) both_flag = 1'b1;
      if ((tx_done || tx_err) && tx_ready) seq_bad = 1'b1;
      if (prev_pulse && !tx_ready && !rst) seq_bad = 1'b1;
      prev_pulse = tx_done | tx_err;
      prev_kclk  = kclk_oe;
      prev_kdata = kdata_oe;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] d);
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (tx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("send_ready_wait", int'(ok), 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("ready_wait", int'(ok), 1);
   endtask

   // Device model: waits for request-to-send, clocks nbits, and for a full
   // frame runs the ACK slot (pulling data low only when ack is set).
   task automatic bfm_frame(input int nbits, input bit ack,
                            output logic [9:0] bits, output int lat);
      bit ok = 1'b0;
      int t0;
      bits = '0;
      lat  = -1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!kclk_oe && kdata_oe && busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("rts_wait", int'(ok), 1);
      repeat (HALF) @(negedge clk);
      for (int k = 0; k < nbits; k++) begin
         bfm_clk_low = 1'b1;
         t0 = cyc;
         for (int j = 0; j < HALF; j++) begin
            @(negedge clk);
            if (k == 0 && lat < 0 && !kdata_oe) lat = cyc - t0;
         end
         bfm_clk_low = 1'b0;
         bits[k] = kdata_line;
         repeat (HALF) @(negedge clk);
      end
      if (nbits == PS2_FRAME_BITS) begin
         if (ack) bfm_data_low = 1'b1;
         repeat (10) @(negedge clk);
         bfm_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         bfm_clk_low = 1'b0;
         repeat (HALF) @(negedge clk);
         bfm_data_low = 1'b0;
      end
   endtask

   // ---------------- test ----------------
   vec_t vecs[4];

   initial begin
      logic [9:0] bits;
      int lat, d0, e0, a0;
      bit ok;

      vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
      vecs[2] = '{8'h01, 1'b1, 1'b0, 1, 0};
      vecs[3] = '{8'hFE, 1'b0, 1'b0, 0, 1};

      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_tx_ready", int'(tx_ready), 0);
      check("rst_tx_done", int'(tx_done), 0);
      check("rst_tx_err", int'(tx_err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_kclk_oe", int'(kclk_oe), 0);
      check("rst_kdata_oe", int'(kdata_oe), 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", int'(tx_ready), 1);

      for (int v = 0; v < 4; v++) begin
         d0 = done_cnt;
         e0 = err_cnt;
         send_byte(vecs[v].data);
         bfm_frame(PS2_FRAME_BITS, vecs[v].ack, bits, lat);
         wait_ready(200);
         check($sformatf("v%0d_data", v), int'(bits[7:0]), int'(vecs[v].data));
         check($sformatf("v%0d_parity", v), int'(bits[8]), int'(vecs[v].exp_par));
         check($sformatf("v%0d_stop", v), int'(bits[9]), 1);
         check($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
         check($sformatf("v%0d_err", v), err_cnt - e0, vecs[v].exp_err);
         check($sformatf("v%0d_kclk_oe_lat", v), kclk_rise_cyc - acc_cyc, 1);
         check($sformatf("v%0d_kdata_oe_lat", v), kdata_rise_cyc - acc_cyc, 1 + INH);
         check($sformatf("v%0d_kclk_rel_lat", v), kclk_fall_cyc - acc_cyc, 1 + INH + HOLD);
         if (vecs[v].data[0]) check($sformatf("v%0d_fall_lat", v), lat, 2 + FLT + 1);
         check($sformatf("v%0d_kclk_idle", v), int'(kclk_oe), 0);
         check($sformatf("v%0d_kdata_idle", v), int'(kdata_oe), 0);
         check($sformatf("v%0d_busy_idle", v), int'(busy), 0);
      end

      // Device stops clocking after four bits: watchdog must fire.
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hF0);
      bfm_frame(4, 1'b0, bits, lat);
      check("tmo_kdata_held", int'(kdata_oe), 1);
      ok = 1'b0;
      for (int i = 0; i < TMO + 200; i++) begin
         @(negedge clk);
         if (err_cnt != e0) begin
            ok = 1'b1;
            break;
         end
      end
      check("tmo_err_seen", int'(ok), 1);
      check("tmo_err_latency", err_cyc - kclk_fall_cyc, TMO);
      check("tmo_kclk_oe", int'(kclk_oe), 0);
      check("tmo_kdata_oe", int'(kdata_oe), 0);
      @(negedge clk);
      check("tmo_ready_after", int'(tx_ready), 1);
      check("tmo_no_done", done_cnt - d0, 0);

      // Reset in the middle of SEND.
      e0 = err_cnt;
      send_byte(8'h00);
      bfm_frame(3, 1'b0, bits, lat);
      check("mid_busy", int'(busy), 1);
      check("mid_kdata_oe", int'(kdata_oe), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_kclk_oe", int'(kclk_oe), 0);
      check("mid_rst_kdata_oe", int'(kdata_oe), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_tx_err", int'(tx_err), 0);
      check("mid_rst_tx_ready", int'(tx_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_ready_after_rst", int'(tx_ready), 1);
      check("mid_no_err", err_cnt - e0, 0);
      d0 = done_cnt;
      send_byte(CMD_RESET);
      bfm_frame(PS2_FRAME_BITS, 1'b1, bits, lat);
      wait_ready(200);
      check("ff_data", int'(bits[7:0]), 255);
      check("ff_parity", int'(bits[8]), 1);
      check("ff_done", done_cnt - d0, 1);

      // tx_valid held with tx_data changing during the transfer.
      d0 = done_cnt;
      a0 = acc_cnt;
      tx_data  = CMD_SET_LEDS;
      tx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("held_first_accept", int'(ok), 1);
      tx_data = 8'h5A;
      bfm_frame(PS2_FRAME_BITS, 1'b1, bits, lat);
      check("held_first_data", int'(bits[7:0]), 237);
      check("held_single_accept", acc_cnt - a0, 1);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_cnt != d0 && busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("held_second_accept", int'(ok), 1);
      tx_valid = 1'b0;
      bfm_frame(PS2_FRAME_BITS, 1'b1, bits, lat);
      wait_ready(200);
      check("held_second_data", int'(bits[7:0]), 90);
      check("held_second_parity", int'(bits[8]), 1);
      check("held_accepts", acc_cnt - a0, 2);
      check("held_done", done_cnt - d0, 2);

      check("never_done_and_err", int'(both_flag), 0);
      check("ready_around_pulse", int'(seq_bad), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
